// File: rtl/cog_ram_loader_if.sv
// Bundles the hub read handshake, the cog execution port and the cog RAM port
// seen by the cog RAM loader.
interface cog_ram_loader_if #(
  parameter int HUB_AW = 14
);
  logic              hub_req;
  logic [HUB_AW-1:0] hub_addr;
  logic              hub_ack;
  logic [31:0]       hub_data;

  logic              cpu_ena;
  logic              cpu_w;
  logic [8:0]        cpu_a;
  logic [31:0]       cpu_d;

  logic              ram_ena;
  logic              ram_w;
  logic [8:0]        ram_a;
  logic [31:0]       ram_d;

  modport master (
    output hub_req, hub_addr,
    input  hub_ack, hub_data,
    input  cpu_ena, cpu_w, cpu_a, cpu_d,
    output ram_ena, ram_w, ram_a, ram_d
  );

  modport slave (
    input  hub_req, hub_addr,
    output hub_ack, hub_data,
    output cpu_ena, cpu_w, cpu_a, cpu_d,
    input  ram_ena, ram_w, ram_a, ram_d
  );
endinterface

// File: rtl/cog_ram_loader.sv
// Owns the cog RAM during a cog (re)start: copies LOAD_COUNT hub longs into
// cog RAM 0..LOAD_COUNT-1, otherwise passes the execution port straight through.
module cog_ram_loader #(
  parameter int LOAD_COUNT = 496,
  parameter int HUB_AW     = 14
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              i_start,
  input  logic [HUB_AW-1:0] i_ptr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cpu_stall,
  cog_ram_loader_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [9:0]        r_count;
  logic [HUB_AW-1:0] r_base;
  logic [31:0]       r_data;
  logic              w_lastLong;
  logic [HUB_AW-1:0] w_hubAddr;

  // count is 10 bits so a full 512-long load still reaches its terminal value
  assign w_lastLong = (r_count == 10'(LOAD_COUNT - 1));
  assign w_hubAddr  = r_base + HUB_AW'(r_count);

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_base  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base  <= i_ptr;
            r_count <= '0;
          end
        end
        S_REQ: begin
          if (bus.hub_ack) r_data <= bus.hub_data;
        end
        S_WRITE: begin
          if (!w_lastLong) r_count <= r_count + 10'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_nextState  = r_state;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    bus.hub_req  = 1'b0;
    bus.hub_addr = '0;
    bus.ram_ena  = 1'b0;
    bus.ram_w    = 1'b0;
    bus.ram_a    = '0;
    bus.ram_d    = '0;

    case (r_state)
      S_IDLE: begin
        o_busy      = 1'b0;
        bus.ram_ena = bus.cpu_ena;
        bus.ram_w   = bus.cpu_w;
        bus.ram_a   = bus.cpu_a;
        bus.ram_d   = bus.cpu_d;
        if (i_start) w_nextState = S_REQ;
      end
      S_REQ: begin
        bus.hub_req  = 1'b1;
        bus.hub_addr = w_hubAddr;
        if (bus.hub_ack) w_nextState = S_WRITE;
      end
      S_WRITE: begin
        bus.ram_ena = 1'b1;
        bus.ram_w   = 1'b1;
        bus.ram_a   = r_count[8:0];
        bus.ram_d   = r_data;
        w_nextState = w_lastLong ? S_DONE : S_REQ;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase

    o_cpu_stall = o_busy;
  end

endmodule

// File: tb/tb_cog_ram_loader.sv
// Directed bench for cog_ram_loader: a hub responder model, a RAM shadow and
// a scoreboard of expected loader writes.
module tb_cog_ram_loader;

  localparam int          LC     = 496;
  localparam int          AW     = 14;
  localparam logic [31:0] XORPAT = 32'hA5A5A5A5;

  typedef struct {
    logic [8:0]  a;
    logic [31:0] d;
  } wr_t;

  logic          clk;
  logic          nres;
  logic          start;
  logic [AW-1:0] ptr;
  logic          busy;
  logic          done;
  logic          stall;

  int nCompared   = 0;
  int nMismatched = 0;
  int waitMode    = 0;
  int totalWaits  = 0;
  int writesSeen  = 0;
  int waitLeft    = 0;
  bit inReq       = 0;
  logic [AW-1:0] reqAddr;

  logic [31:0] ramModel [512];
  wr_t         sbQ [$];

  cog_ram_loader_if #(.HUB_AW(AW)) bus ();

  cog_ram_loader #(.LOAD_COUNT(LC), .HUB_AW(AW)) dut (
    .clk         (clk),
    .nres        (nres),
    .i_start     (start),
    .i_ptr       (ptr),
    .o_busy      (busy),
    .o_done      (done),
    .o_cpu_stall (stall),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] hubWord(input logic [AW-1:0] a);
    return {{(32-AW){1'b0}}, a} ^ XORPAT;
  endfunction

  // Hub responder: acks after 0 (or 0..3 random) wait cycles, checks address hold
  always @(negedge clk) begin
    if (!nres) begin
      bus.hub_ack  = 1'b0;
      bus.hub_data = '0;
      inReq        = 0;
    end else if (bus.hub_req) begin
      if (!inReq) begin
        inReq      = 1;
        waitLeft   = (waitMode != 0) ? int'($urandom_range(0, 3)) : 0;
        totalWaits += waitLeft;
        reqAddr    = bus.hub_addr;
      end else begin
        checkOutput("hub_addr_stable", 32'(bus.hub_addr), 32'(reqAddr));
      end
      if (waitLeft == 0) begin
        bus.hub_ack  = 1'b1;
        bus.hub_data = hubWord(bus.hub_addr);
      end else begin
        bus.hub_ack  = 1'b0;
        bus.hub_data = 32'h0BAD0BAD;
        waitLeft--;
      end
    end else begin
      bus.hub_ack  = 1'b0;
      bus.hub_data = 32'hFFFFFFFF;
      inReq        = 0;
    end
  end

  // RAM shadow plus scoreboard pop for every write made while the loader is busy
  always @(negedge clk) begin
    wr_t e;
    if (nres && bus.ram_ena && bus.ram_w) begin
      ramModel[bus.ram_a] = bus.ram_d;
      if (busy) begin
        checkOutput("sb_pending", {31'b0, sbQ.size() != 0}, 32'd1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkOutput("ram_a", 32'(bus.ram_a), 32'(e.a));
          checkOutput("ram_d", bus.ram_d, e.d);
          writesSeen++;
        end
      end
    end
  end

  task automatic pushLoad(input logic [AW-1:0] p);
    wr_t e;
    for (int k = 0; k < LC; k++) begin
      e.a = 9'(k);
      e.d = hubWord(p + AW'(k));
      sbQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] p, input int mode, input bit inject);
    int n;
    pushLoad(p);
    totalWaits = 0;
    waitMode   = mode;
    @(negedge clk);
    ptr   = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ptr   = AW'($urandom);
    n     = 0;
    while (n < 4000) begin
      @(posedge clk);
      n++;
      #1;
      if (inject && n == 50) begin
        start       = 1'b1;
        ptr         = 14'h2000;
        bus.cpu_ena = 1'b1;
        bus.cpu_w   = 1'b1;
        bus.cpu_a   = 9'h000;
        bus.cpu_d   = 32'h12345678;
      end
      if (inject && n >= 50 && n <= 60) checkOutput("cpu_stall_mid", 32'(stall), 32'd1);
      if (inject && n == 61) begin
        start       = 1'b0;
        bus.cpu_ena = 1'b0;
        bus.cpu_w   = 1'b0;
      end
      if (done) break;
    end
    checkOutput("done_cycle", n, 2 * LC + totalWaits);
    checkOutput("sb_drained", sbQ.size(), 0);
    @(posedge clk);
    #1;
    checkOutput("done_single", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    sbQ.delete();
  endtask

  initial begin
    int n;
    start       = 1'b0;
    ptr         = '0;
    bus.cpu_ena = 1'b0;
    bus.cpu_w   = 1'b0;
    bus.cpu_a   = '0;
    bus.cpu_d   = '0;
    bus.hub_ack = 1'b0;
    bus.hub_data = '0;
    nres        = 1'b0;

    // Reset with random-ish inputs; RAM mux must be passthrough
    #3;
    start       = 1'b1;
    ptr         = AW'($urandom);
    bus.cpu_ena = 1'b1;
    bus.cpu_w   = 1'b1;
    bus.cpu_a   = 9'h1F0;
    bus.cpu_d   = 32'hDEADBEEF;
    #20;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_hub_req", 32'(bus.hub_req), 32'd0);
    checkOutput("rst_hub_addr", 32'(bus.hub_addr), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_ram_ena", 32'(bus.ram_ena), 32'd1);
    checkOutput("rst_ram_w", 32'(bus.ram_w), 32'd1);
    checkOutput("rst_ram_a", 32'(bus.ram_a), 32'h1F0);
    checkOutput("rst_ram_d", bus.ram_d, 32'hDEADBEEF);

    bus.cpu_ena = 1'b0;
    bus.cpu_w   = 1'b0;
    start       = 1'b0;
    for (int i = 0; i < 512; i++) ramModel[i] = 32'hC0DE0000 | 32'(i);
    @(negedge clk);
    nres = 1'b1;
    @(negedge clk);
    bus.cpu_a = 9'h155;
    bus.cpu_d = 32'h5A5A0001;
    #1;
    checkOutput("idle_pass_a", 32'(bus.ram_a), 32'h155);
    checkOutput("idle_pass_d", bus.ram_d, 32'h5A5A0001);
    bus.cpu_a = '0;

    // Full load, zero-wait hub
    $display("[TB] full load, zero wait");
    applyStimulus(14'h0100, 0, 0);
    checkOutput("ram_1EF", ramModel[9'h1EF], 32'h02EF ^ XORPAT);
    checkOutput("ram_000", ramModel[0], 32'h0100 ^ XORPAT);
    for (int i = 9'h1F0; i < 512; i++) checkOutput("ram_high_untouched", ramModel[i], 32'hC0DE0000 | 32'(i));

    // Random hub wait states
    $display("[TB] load with random wait states");
    applyStimulus(14'h0A00, 1, 0);
    checkOutput("ram_wait_last", ramModel[LC-1], hubWord(14'h0A00 + AW'(LC - 1)));

    // Hub address wrap
    $display("[TB] address wrap");
    applyStimulus(14'h3FF8, 0, 0);
    checkOutput("wrap_ram_7", ramModel[7], 32'h3FFF ^ XORPAT);
    checkOutput("wrap_ram_8", ramModel[8], 32'h0000 ^ XORPAT);

    // Busy masking: start + cpu write to address 0 mid-load
    $display("[TB] busy masking");
    applyStimulus(14'h0300, 1, 1);
    checkOutput("mask_ram_0", ramModel[0], 32'h0300 ^ XORPAT);

    // Reset mid-load after 100 longs, then reload from long 0
    $display("[TB] reset mid-load");
    for (int i = 0; i < 512; i++) ramModel[i] = 32'hC0DE0000 | 32'(i);
    pushLoad(14'h1000);
    totalWaits = 0;
    waitMode   = 1;
    writesSeen = 0;
    @(negedge clk);
    ptr   = 14'h1000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (writesSeen < 100 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("reach_long100", writesSeen, 100);
    @(posedge clk);
    #2;
    nres = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_hub_req", 32'(bus.hub_req), 32'd0);
    checkOutput("mid_rst_hub_addr", 32'(bus.hub_addr), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    sbQ.delete();
    for (int i = 0; i < 100; i++) checkOutput("mid_rst_kept", ramModel[i], hubWord(14'h1000 + AW'(i)));
    checkOutput("mid_rst_100_untouched", ramModel[100], 32'hC0DE0000 | 32'd100);
    @(negedge clk);
    nres = 1'b1;
    applyStimulus(14'h0200, 0, 0);
    checkOutput("reload_ram_0", ramModel[0], 32'h0200 ^ XORPAT);
    checkOutput("reload_ram_100", ramModel[100], 32'h0264 ^ XORPAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cog_ram_loader.md
Name: cog_ram_loader

Overview:
- Controller that owns the cog's 512x32 single-port cog RAM during a cog (re)start.
- On a start pulse, copies LOAD_COUNT consecutive longs from hub memory into cog RAM addresses 0..LOAD_COUNT-1 using a req/ack hub handshake.
- While idle, it passes the cog execution port straight through to the RAM.
- While loading, it stalls the execution port and masks its accesses.

Parameters:
- LOAD_COUNT, 496, number of longs copied per load (legal 1..512).
- HUB_AW, 14, hub long-address width; addresses wrap modulo 2^HUB_AW.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- nres  in  1  reset, asynchronous assert, active-low.
- start  in  1  load request pulse; sampled only in IDLE.
- ptr  in  HUB_AW  hub long address of the first long; captured on an accepted start.
- busy  out  1  high in REQ, WRITE and DONE states.
- done  out  1  single-cycle pulse in the DONE state.
- hub_req  out  1  hub read request.
- hub_addr  out  HUB_AW  hub long address; valid while hub_req=1.
- hub_ack  in  1  hub read complete; hub_data valid in the same cycle.
- hub_data  in  32  hub read data.
- cpu_ena  in  1  execution-port RAM enable.
- cpu_w  in  1  execution-port write.
- cpu_a  in  9  execution-port address.
- cpu_d  in  32  execution-port write data.
- cpu_stall  out  1  equals busy; the execution unit must hold while high.
- ram_ena  out  1  to cog RAM ena.
- ram_w  out  1  to cog RAM w.
- ram_a  out  9  to cog RAM a.
- ram_d  out  32  to cog RAM d.
- Cog RAM q is routed directly to the execution unit, not through this block.

Behaviour:
- Reset (nres=0, async):
  - state=IDLE, count=0, base=0, data register=0.
  - busy=0, done=0, hub_req=0, hub_addr=0.
  - The RAM mux is in passthrough.
  - Reset mid-load abandons the load; RAM contents already written stay as written.
- State register is one-hot or binary (implementer's choice). All outputs decode from registered state; no input-to-output combinational path except IDLE passthrough.
- IDLE:
  - ram_ena/w/a/d = cpu_ena/w/a/d.
  - On start=1: base<=ptr, count<=0, go to REQ.
- REQ:
  - hub_req=1, hub_addr=(base+count) mod 2^HUB_AW. Width-truncating add; no carry out.
  - ram_ena=0.
  - On hub_ack=1: data<=hub_data, go to WRITE.
  - Otherwise stay in REQ; any number of wait cycles is allowed.
- WRITE:
  - hub_req=0; ram_ena=1, ram_w=1, ram_a=count[8:0], ram_d=data.
  - If count==LOAD_COUNT-1, go to DONE. Otherwise count<=count+1 and go to REQ.
- DONE:
  - done=1 for exactly one cycle, ram_ena=0, then go to IDLE.
- Outside IDLE, cpu_* inputs are ignored and no execution-port write reaches the RAM.
- start outside IDLE (including the DONE cycle) is ignored; ptr is not recaptured.
- hub_ack outside REQ is ignored.
- Latency with hub_ack high on the first REQ cycle:
  - Start accepted at edge 0 → REQ at cycle 1, WRITE at cycle 2.
  - Long k is written at cycle 2k+2.
  - DONE at cycle 2*LOAD_COUNT+1; IDLE passthrough at 2*LOAD_COUNT+2.
  - Each hub wait cycle adds one cycle.
- count is 10 bits wide so LOAD_COUNT=512 terminates correctly. ram_a uses count[8:0].
- RAM locations ≥ LOAD_COUNT are never touched by the loader.

Test Plan:
- Reset: nres low with random inputs → busy=0, done=0, hub_req=0, hub_addr=0; ram_* equals cpu_* (cpu_w=1, cpu_a=0x1F0, cpu_d=0xDEADBEEF seen on ram_*).
- Full load, zero-wait hub: ptr=0x0100, hub_data=addr XOR 0xA5A5A5A5, ack every REQ cycle.
  - 496 writes, hub_addr 0x0100..0x02EF.
  - RAM[0x1EF]=0x02EF^0xA5A5A5A5.
  - done pulse at cycle 993; RAM[0x1F0..0x1FF] unchanged.
- Wait states: ack delayed 0..3 random cycles.
  - hub_req holds and hub_addr is stable while waiting.
  - Every long is written exactly once, in order.
  - done arrives at 2*496+1+total_waits.
- Wrap: ptr=0x3FF8, LOAD_COUNT=496 → hub_addr sequence 0x3FF8..0x3FFF, 0x0000..0x01E7; RAM[8] holds hub long 0x0000.
- Busy masking: start pulse and cpu_w=1 to cpu_a=0x000 mid-load.
  - ptr is not recaptured and the load sequence is unchanged.
  - RAM[0] holds hub data, not cpu_d.
  - cpu_stall=1 throughout.
- Reset mid-load: nres low at long 100.
  - Outputs clear immediately without waiting for clk.
  - RAM[0..99] hold loaded data.
  - A new start then reloads from long 0.
